// File: rtl/homing_sequencer.sv
// homing_sequencer: drives the motor toward the home switch, backs off, then
// reports homed or fault. The raw switch is synchronized and debounced, and the
// seek is guarded by a timeout.
// Optional macro HOMING_SECOND_PASS_EN adds a slow 25%-duty CREEP re-approach
// after BACKOFF; when undefined BACKOFF goes straight to DONE.
module homing_sequencer #(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned BACKOFF_MS  = 200,
  parameter int unsigned TIMEOUT_S   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic home_sw,
  output logic motor_fwd,
  output logic motor_rev,
  output logic busy,
  output logic homed,
  output logic fault
);

  localparam int unsigned DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned BO_CYC  = CLK_HZ / 1000 * BACKOFF_MS;
  localparam int unsigned TO_CYC  = CLK_HZ * TIMEOUT_S;
  localparam int unsigned CNT_MAX = (TO_CYC > BO_CYC) ? TO_CYC : BO_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEEK    = 3'd1,
    BACKOFF = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4,
    CREEP   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sw_db;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic               w_fwd;
  logic               w_rev;
  logic               w_busy;
  logic               w_homed;
  logic               w_fault;

  // Two-flop synchronizer plus debounce: accept a new level only after it has
  // differed from the current one for DEB_CYC consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sw_db   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= home_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_sw_db) begin
        if (r_deb_cnt == DEB_W'(DEB_CYC - 1)) begin
          r_sw_db   <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

`ifdef HOMING_SECOND_PASS_EN
  logic [1:0] r_phase;

  // Free-running phase for the 1-of-4 creep pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 2'd0;
    end else begin
      r_phase <= r_phase + 2'd1;
    end
  end
`endif

  // State and shared timeout/backoff counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next state and counter; dropping enable aborts from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SEEK;
          w_cnt_nxt   = '0;
        end
        SEEK: begin
          if (r_sw_db) begin
            w_state_nxt = BACKOFF;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_W'(TO_CYC)) begin
            w_state_nxt = FAULT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        BACKOFF: begin
          if (w_cnt_inc == CNT_W'(BO_CYC)) begin
`ifdef HOMING_SECOND_PASS_EN
            w_state_nxt = CREEP;
`else
            w_state_nxt = DONE;
`endif
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
`ifdef HOMING_SECOND_PASS_EN
        CREEP: begin
          if (r_sw_db) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_W'(TO_CYC)) begin
            w_state_nxt = FAULT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
`endif
        DONE:    w_cnt_nxt = '0;
        FAULT:   w_cnt_nxt = '0;
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the current state; forced low when aborting so the
  // outputs clear on the same edge the state returns to IDLE.
  always_comb begin
    w_fwd   = 1'b0;
    w_rev   = 1'b0;
    w_busy  = 1'b0;
    w_homed = 1'b0;
    w_fault = 1'b0;
    if (enable) begin
      case (r_state)
        SEEK: begin
          w_rev  = 1'b1;
          w_busy = 1'b1;
        end
        BACKOFF: begin
          w_fwd  = 1'b1;
          w_busy = 1'b1;
        end
`ifdef HOMING_SECOND_PASS_EN
        CREEP: begin
          w_rev  = (r_phase == 2'd0);
          w_busy = 1'b1;
        end
`endif
        DONE:    w_homed = 1'b1;
        FAULT:   w_fault = 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
      busy      <= 1'b0;
      homed     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      motor_fwd <= w_fwd;
      motor_rev <= w_rev;
      busy      <= w_busy;
      homed     <= w_homed;
      fault     <= w_fault;
    end
  end

endmodule
